// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone bus arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_OWN_M0 = 2'd1,
    ARB_OWN_M1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  // One-hot owner indication derived from the arbiter state.
  function automatic logic [1:0] grant_of(input arb_state_t state);
    case (state)
      ARB_OWN_M0: grant_of = GRANT_M0;
      ARB_OWN_M1: grant_of = GRANT_M1;
      default:    grant_of = GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// No-ack watchdog: counts consecutive strobed cycles without an ack and
// pulses expire on the cycle that would make the wait reach TIMEOUT.
// TIMEOUT = 0 removes the counter entirely and expire is tied low.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off

    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, active, ack};
    assign expire        = 1'b0;

  end else begin : g_on

    localparam int              CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expire = active && !ack && (count == LAST);

    // Wait counter: restarts whenever the access completes, the owner stops
    // strobing, or the watchdog fires, so it can never run past LAST.
    always_ff @(posedge clk) begin
      if (!reset) begin
        count <= '0;
      end else if (!active || ack || expire) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end

  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: m0 (data port) and m1 (instruction port)
// share one slave bus. A master keeps the bus for its whole cyc, responses
// go only to the owner, and a watchdog ends hung accesses with err.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_ack_o,
  output logic                    m0_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,

  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_ack_o,
  output logic                    m1_wb_err_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,

  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,

  output logic [1:0]              grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  arb_state_t state;
  arb_state_t state_next;
  logic       last_owner;
  logic       last_owner_next;

  logic                  own_cyc;
  logic                  own_stb;
  logic                  own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat;
  logic [SEL_WIDTH-1:0]  own_sel;

  logic wd_active;
  logic expire;

  assign wd_active = own_cyc && own_stb;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active (wd_active),
    .ack    (s_wb_ack_i),
    .expire (expire)
  );

  // State and last-owner registers; last_owner starts at m1 so m0 wins the
  // first tie after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
    end
  end

  // Arbitration in IDLE, release on cyc drop or watchdog expiry while owned.
  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    case (state)
      ARB_IDLE: begin
        if (m0_wb_cyc_i && m1_wb_cyc_i) begin
          state_next = (RR_MODE != 0 && !last_owner) ? ARB_OWN_M1 : ARB_OWN_M0;
        end else if (m0_wb_cyc_i) begin
          state_next = ARB_OWN_M0;
        end else if (m1_wb_cyc_i) begin
          state_next = ARB_OWN_M1;
        end
      end
      ARB_OWN_M0: begin
        if (!m0_wb_cyc_i || expire) begin
          state_next      = ARB_IDLE;
          last_owner_next = 1'b0;
        end
      end
      ARB_OWN_M1: begin
        if (!m1_wb_cyc_i || expire) begin
          state_next      = ARB_IDLE;
          last_owner_next = 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Select the current owner's request signals; everything is zero in IDLE.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    case (state)
      ARB_OWN_M0: begin
        own_cyc = m0_wb_cyc_i;
        own_stb = m0_wb_stb_i;
        own_we  = m0_wb_we_i;
        own_adr = m0_wb_adr_i;
        own_dat = m0_wb_dat_i;
        own_sel = m0_wb_sel_i;
      end
      ARB_OWN_M1: begin
        own_cyc = m1_wb_cyc_i;
        own_stb = m1_wb_stb_i;
        own_we  = m1_wb_we_i;
        own_adr = m1_wb_adr_i;
        own_dat = m1_wb_dat_i;
        own_sel = m1_wb_sel_i;
      end
      default: begin
      end
    endcase
  end

  // Drive the slave bus from the owner and route ack/err back to it only;
  // an expiring watchdog pulls cyc/stb low in the same cycle it raises err.
  always_comb begin
    s_wb_cyc_o  = own_cyc && !expire;
    s_wb_stb_o  = own_cyc && own_stb && !expire;
    s_wb_we_o   = own_we;
    s_wb_adr_o  = own_adr;
    s_wb_dat_o  = own_dat;
    s_wb_sel_o  = own_sel;
    m0_wb_ack_o = 1'b0;
    m0_wb_err_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    m1_wb_err_o = 1'b0;
    case (state)
      ARB_OWN_M0: begin
        m0_wb_ack_o = s_wb_ack_i;
        m0_wb_err_o = expire;
      end
      ARB_OWN_M1: begin
        m1_wb_ack_o = s_wb_ack_i;
        m1_wb_err_o = expire;
      end
      default: begin
      end
    endcase
  end

  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign grant_o     = grant_of(state);

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: two instances (round-robin with a short watchdog,
// fixed priority with no watchdog) share the same stimulus; a reference model
// predicts each cycle's outputs into per-instance queues and a negedge
// monitor pops and compares.
module tb_wb_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          rst_n;
    logic          m0_cyc;
    logic          m0_stb;
    logic          m0_we;
    logic [AW-1:0] m0_adr;
    logic [DW-1:0] m0_dat;
    logic [SW-1:0] m0_sel;
    logic          m1_cyc;
    logic          m1_stb;
    logic          m1_we;
    logic [AW-1:0] m1_adr;
    logic [DW-1:0] m1_dat;
    logic [SW-1:0] m1_sel;
    logic          s_ack;
    logic [DW-1:0] s_dat;
  } stim_t;

  typedef struct packed {
    logic [1:0]    grant;
    logic          s_cyc;
    logic          s_stb;
    logic          s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;
    logic          m0_ack;
    logic          m0_err;
    logic          m1_ack;
    logic          m1_err;
    logic [DW-1:0] m0_dat;
    logic [DW-1:0] m1_dat;
  } resp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_adr = '0;
  logic [DW-1:0] m0_dat = '0;
  logic [SW-1:0] m0_sel = '0;
  logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_adr = '0;
  logic [DW-1:0] m1_dat = '0;
  logic [SW-1:0] m1_sel = '0;
  logic          s_ack = 1'b0;
  logic [DW-1:0] s_dat_in = '0;

  logic          a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic [DW-1:0] a_m0_dat, a_m1_dat;
  logic          a_s_cyc, a_s_stb, a_s_we;
  logic [AW-1:0] a_s_adr;
  logic [DW-1:0] a_s_dat;
  logic [SW-1:0] a_s_sel;
  logic [1:0]    a_grant;

  logic          b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [DW-1:0] b_m0_dat, b_m1_dat;
  logic          b_s_cyc, b_s_stb, b_s_we;
  logic [AW-1:0] b_s_adr;
  logic [DW-1:0] b_s_dat;
  logic [SW-1:0] b_s_sel;
  logic [1:0]    b_grant;

  resp_t act_a, act_b;
  assign act_a = {a_grant, a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_dat, a_s_sel,
                  a_m0_ack, a_m0_err, a_m1_ack, a_m1_err, a_m0_dat, a_m1_dat};
  assign act_b = {b_grant, b_s_cyc, b_s_stb, b_s_we, b_s_adr, b_s_dat, b_s_sel,
                  b_m0_ack, b_m0_err, b_m1_ack, b_m1_err, b_m0_dat, b_m1_dat};

  always #5 clk = ~clk;

  wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1), .TIMEOUT(4)) u_dut_a (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(a_m0_ack), .m0_wb_err_o(a_m0_err), .m0_wb_dat_o(a_m0_dat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(a_m1_ack), .m1_wb_err_o(a_m1_err), .m1_wb_dat_o(a_m1_dat),
    .s_wb_cyc_o(a_s_cyc), .s_wb_stb_o(a_s_stb), .s_wb_we_o(a_s_we),
    .s_wb_adr_o(a_s_adr), .s_wb_dat_o(a_s_dat), .s_wb_sel_o(a_s_sel),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_dat_in),
    .grant_o(a_grant)
  );

  wb_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0), .TIMEOUT(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(b_m0_ack), .m0_wb_err_o(b_m0_err), .m0_wb_dat_o(b_m0_dat),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(b_m1_ack), .m1_wb_err_o(b_m1_err), .m1_wb_dat_o(b_m1_dat),
    .s_wb_cyc_o(b_s_cyc), .s_wb_stb_o(b_s_stb), .s_wb_we_o(b_s_we),
    .s_wb_adr_o(b_s_adr), .s_wb_dat_o(b_s_dat), .s_wb_sel_o(b_s_sel),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_dat_in),
    .grant_o(b_grant)
  );

  int total = 0;
  int bad = 0;
  int cycle_n = 0;
  bit chk_on = 1'b0;

  resp_t exp_q0[$];
  resp_t exp_q1[$];

  // Reference model state: owner -1 = nobody, 0 = m0, 1 = m1.
  int own [2]      = '{-1, -1};
  int last [2]     = '{1, 1};
  int wait_cnt [2] = '{0, 0};
  int rr [2]       = '{1, 0};
  int tmo [2]      = '{4, 0};

  // Predict this cycle's outputs of instance k, then advance its state.
  task automatic modelStep(input int k, input stim_t s, output resp_t e);
    logic cyc, stb, hung, expire;
    e = '0;
    e.m0_dat = s.s_dat;
    e.m1_dat = s.s_dat;
    if (own[k] >= 0) begin
      cyc    = (own[k] == 0) ? s.m0_cyc : s.m1_cyc;
      stb    = (own[k] == 0) ? s.m0_stb : s.m1_stb;
      hung   = cyc && stb && !s.s_ack;
      expire = hung && (tmo[k] > 0) && (wait_cnt[k] == tmo[k] - 1);
      e.grant = (own[k] == 0) ? 2'b01 : 2'b10;
      e.s_cyc = cyc && !expire;
      e.s_stb = cyc && stb && !expire;
      e.s_we  = (own[k] == 0) ? s.m0_we  : s.m1_we;
      e.s_adr = (own[k] == 0) ? s.m0_adr : s.m1_adr;
      e.s_dat = (own[k] == 0) ? s.m0_dat : s.m1_dat;
      e.s_sel = (own[k] == 0) ? s.m0_sel : s.m1_sel;
      if (own[k] == 0) begin
        e.m0_ack = s.s_ack;
        e.m0_err = expire;
      end else begin
        e.m1_ack = s.s_ack;
        e.m1_err = expire;
      end
      wait_cnt[k] = (hung && !expire) ? wait_cnt[k] + 1 : 0;
      if (!cyc || expire) begin
        last[k] = own[k];
        own[k]  = -1;
      end
    end else begin
      wait_cnt[k] = 0;
      if (s.m0_cyc && s.m1_cyc) own[k] = (rr[k] != 0) ? 1 - last[k] : 0;
      else if (s.m0_cyc)        own[k] = 0;
      else if (s.m1_cyc)        own[k] = 1;
    end
    if (!s.rst_n) begin
      own[k]      = -1;
      last[k]     = 1;
      wait_cnt[k] = 0;
    end
  endtask

  // Drive one cycle of inputs and queue the predicted response of both DUTs.
  task automatic applyStimulus(input stim_t s);
    resp_t e0, e1;
    @(posedge clk);
    #1;
    reset = s.rst_n;
    m0_cyc = s.m0_cyc; m0_stb = s.m0_stb; m0_we = s.m0_we;
    m0_adr = s.m0_adr; m0_dat = s.m0_dat; m0_sel = s.m0_sel;
    m1_cyc = s.m1_cyc; m1_stb = s.m1_stb; m1_we = s.m1_we;
    m1_adr = s.m1_adr; m1_dat = s.m1_dat; m1_sel = s.m1_sel;
    s_ack = s.s_ack; s_dat_in = s.s_dat;
    modelStep(0, s, e0);
    modelStep(1, s, e1);
    exp_q0.push_back(e0);
    exp_q1.push_back(e1);
    cycle_n++;
    chk_on = 1'b1;
  endtask

  task automatic checkOutput(input string name, input resp_t got, input resp_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got grant=%b cyc=%b ack=%b%b err=%b%b (%h) want grant=%b cyc=%b ack=%b%b err=%b%b (%h)",
               name, cycle_n, got.grant, got.s_cyc, got.m0_ack, got.m1_ack, got.m0_err, got.m1_err, got,
               want.grant, want.s_cyc, want.m0_ack, want.m1_ack, want.m0_err, want.m1_err, want);
    end
  endtask

  task automatic checkValue(input string name, input logic [1:0] got, input logic [1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  // Sample both DUTs mid-cycle and compare against the oldest prediction.
  always @(negedge clk) begin
    if (chk_on) begin
      if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL scoreboard underflow at cycle %0d", cycle_n);
      end else begin
        checkOutput("dutA", act_a, exp_q0.pop_front());
        checkOutput("dutB", act_b, exp_q1.pop_front());
      end
    end
  end

  function automatic stim_t idleStim();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.s_dat = $urandom;
    return s;
  endfunction

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  initial begin
    stim_t s;
    $display("[TB] start");
    repeat (2) @(posedge clk);

    // Reset held: outputs must be idle.
    s = idleStim();
    s.rst_n = 1'b0;
    applyStimulus(s);
    applyStimulus(idleStim());

    // Single m1 read acked after two cycles.
    s = idleStim();
    s.m1_cyc = 1'b1; s.m1_stb = 1'b1; s.m1_adr = 32'h8000_0000; s.m1_sel = 4'hf;
    applyStimulus(s);
    applyStimulus(s);
    sampleNow();
    checkValue("m1 read grant", a_grant, 2'b10);
    checkValue("m1 read s_cyc", {1'b0, a_s_cyc}, 2'b01);
    applyStimulus(s);
    s.s_ack = 1'b1;
    applyStimulus(s);
    sampleNow();
    checkValue("m1 read ack", {a_m0_ack, a_m1_ack}, 2'b01);
    repeat (2) applyStimulus(idleStim());

    // Tie: m0 wins, holds for three stb/ack pairs while m1 waits.
    s = idleStim();
    s.m0_cyc = 1'b1; s.m0_stb = 1'b1; s.m0_adr = 32'h0000_1000; s.m0_we = 1'b1; s.m0_dat = 32'hcafe_0001;
    s.m1_cyc = 1'b1; s.m1_stb = 1'b1; s.m1_adr = 32'h8000_0004;
    applyStimulus(s);
    applyStimulus(s);
    sampleNow();
    checkValue("tie A grant", a_grant, 2'b01);
    checkValue("tie B grant", b_grant, 2'b01);
    s.s_ack = 1'b1; applyStimulus(s);
    s.s_ack = 1'b0; s.m0_stb = 1'b0; applyStimulus(s);
    s.s_ack = 1'b1; s.m0_stb = 1'b1; applyStimulus(s);
    s.s_ack = 1'b0; s.m0_stb = 1'b0; applyStimulus(s);
    s.s_ack = 1'b1; s.m0_stb = 1'b1; applyStimulus(s);
    sampleNow();
    checkValue("hold grant", a_grant, 2'b01);
    checkValue("m1 starved ack", {1'b0, a_m1_ack}, 2'b00);
    s.s_ack = 1'b0; s.m0_cyc = 1'b0; s.m0_stb = 1'b0;
    applyStimulus(s);
    s.m0_cyc = 1'b1; s.m0_stb = 1'b1;
    applyStimulus(s);
    sampleNow();
    checkValue("idle gap", a_grant, 2'b00);
    applyStimulus(s);
    sampleNow();
    checkValue("rr second owner", a_grant, 2'b10);
    checkValue("fixed prio owner", b_grant, 2'b01);
    repeat (3) applyStimulus(idleStim());

    // Watchdog: m0 write never acked.
    s = idleStim();
    s.m0_cyc = 1'b1; s.m0_stb = 1'b1; s.m0_we = 1'b1; s.m0_adr = 32'h0000_2000; s.m0_sel = 4'h3;
    repeat (4) applyStimulus(s);
    applyStimulus(s);
    sampleNow();
    checkValue("timeout err", {a_m0_err, a_s_cyc}, 2'b10);
    applyStimulus(s);
    sampleNow();
    checkValue("timeout release", a_grant, 2'b00);
    repeat (3) applyStimulus(idleStim());

    // Ack exactly on the timeout cycle beats the error.
    repeat (4) applyStimulus(s);
    s.s_ack = 1'b1;
    applyStimulus(s);
    sampleNow();
    checkValue("ack beats timeout", {a_m0_ack, a_m0_err}, 2'b10);
    repeat (3) applyStimulus(idleStim());

    // Reset asserted mid-access on m1, then a tie goes to m0.
    s = idleStim();
    s.m1_cyc = 1'b1; s.m1_stb = 1'b1; s.m1_adr = 32'h8000_0010;
    applyStimulus(s);
    applyStimulus(s);
    s.rst_n = 1'b0;
    applyStimulus(s);
    s = idleStim();
    s.s_ack = 1'b1;
    applyStimulus(s);
    sampleNow();
    checkValue("post reset grant", a_grant, 2'b00);
    checkValue("post reset ack", {a_m1_ack, a_s_cyc}, 2'b00);
    s = idleStim();
    s.m0_cyc = 1'b1; s.m0_stb = 1'b1; s.m1_cyc = 1'b1; s.m1_stb = 1'b1;
    applyStimulus(s);
    applyStimulus(s);
    sampleNow();
    checkValue("post reset tie", a_grant, 2'b01);
    repeat (3) applyStimulus(idleStim());

    // Randomized traffic with persistent cyc, sparse acks and rare resets.
    s = idleStim();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) s.m0_cyc = ~s.m0_cyc;
      if ($urandom_range(5) == 0) s.m1_cyc = ~s.m1_cyc;
      s.m0_stb = s.m0_cyc ? ($urandom_range(4) != 0) : ($urandom_range(9) == 0);
      s.m1_stb = s.m1_cyc ? ($urandom_range(4) != 0) : ($urandom_range(9) == 0);
      s.m0_we  = ($urandom_range(1) == 1);
      s.m1_we  = ($urandom_range(1) == 1);
      s.m0_adr = $urandom;
      s.m1_adr = $urandom;
      s.m0_dat = $urandom;
      s.m1_dat = $urandom;
      s.m0_sel = 4'($urandom);
      s.m1_sel = 4'($urandom);
      s.s_ack  = ($urandom_range(3) == 0);
      s.s_dat  = $urandom;
      s.rst_n  = ($urandom_range(199) != 0);
      applyStimulus(s);
    end

    @(posedge clk);
    chk_on = 1'b0;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard leftover: got %0d/%0d entries want 0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
